// File: rtl/relu_maxpool_8chanel.sv
`default_nettype none
// ============================================================================
//  Module   : relu_maxpool_8chanel
//  Function : Per-channel ReLU followed by 2x2 stride-2 max pooling over eight
//             IEEE-754 single-precision raster streams.
//  Revision : 1.0 - initial release
// ============================================================================
module relu_maxpool_8chanel #(
    parameter int WIDTH  = 16,
    parameter int HEIGHT = 16,
    parameter int FILTER = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_valid_in,
    input  logic [31:0] data_in0,
    input  logic [31:0] data_in1,
    input  logic [31:0] data_in2,
    input  logic [31:0] data_in3,
    input  logic [31:0] data_in4,
    input  logic [31:0] data_in5,
    input  logic [31:0] data_in6,
    input  logic [31:0] data_in7,
    output logic [31:0] data_out0,
    output logic [31:0] data_out1,
    output logic [31:0] data_out2,
    output logic [31:0] data_out3,
    output logic [31:0] data_out4,
    output logic [31:0] data_out5,
    output logic [31:0] data_out6,
    output logic [31:0] data_out7,
    output logic        valid_out,
    output logic        done_img
);

    localparam int c_NCH    = 8;
    localparam int c_HALF_W = WIDTH / 2;
    localparam int c_COL_W  = (WIDTH  > 2) ? $clog2(WIDTH)  : 1;
    localparam int c_ROW_W  = (HEIGHT > 2) ? $clog2(HEIGHT) : 1;
    localparam int c_LB_AW  = (c_HALF_W > 1) ? $clog2(c_HALF_W) : 1;

    if ((WIDTH % 2) != 0 || WIDTH < 2) begin : g_bad_width
        $error("relu_maxpool_8chanel: WIDTH must be even and >= 2");
    end
    if ((HEIGHT % 2) != 0 || HEIGHT < 2) begin : g_bad_height
        $error("relu_maxpool_8chanel: HEIGHT must be even and >= 2");
    end
    if (FILTER != c_NCH) begin : g_bad_filter
        $error("relu_maxpool_8chanel: FILTER must be 8");
    end

    // Negative values (including -0.0) collapse to +0.0.
    function automatic logic [31:0] f_relu(input logic [31:0] x);
        return x[31] ? 32'h0000_0000 : x;
    endfunction

    // Both operands are non-negative floats, so magnitude bits order them.
    function automatic logic [31:0] f_max(input logic [31:0] a, input logic [31:0] b);
        return (a[30:0] >= b[30:0]) ? a : b;
    endfunction

    logic [31:0]        w_in    [c_NCH];
    logic [31:0]        w_relu  [c_NCH];
    logic [31:0]        w_pair  [c_NCH];
    logic [31:0]        w_quad  [c_NCH];
    logic [31:0]        r_h     [c_NCH];
    logic [31:0]        r_dout  [c_NCH];
    logic [31:0]        r_lb    [c_NCH][c_HALF_W];
    logic [c_COL_W-1:0] r_col;
    logic [c_ROW_W-1:0] r_row;
    logic               r_valid;
    logic               r_done;
    logic               w_col_last;
    logic               w_row_last;
    logic               w_odd_col;
    logic               w_odd_row;
    logic [c_LB_AW-1:0] w_lb_addr;

    assign w_in[0] = data_in0;
    assign w_in[1] = data_in1;
    assign w_in[2] = data_in2;
    assign w_in[3] = data_in3;
    assign w_in[4] = data_in4;
    assign w_in[5] = data_in5;
    assign w_in[6] = data_in6;
    assign w_in[7] = data_in7;

    assign data_out0 = r_dout[0];
    assign data_out1 = r_dout[1];
    assign data_out2 = r_dout[2];
    assign data_out3 = r_dout[3];
    assign data_out4 = r_dout[4];
    assign data_out5 = r_dout[5];
    assign data_out6 = r_dout[6];
    assign data_out7 = r_dout[7];
    assign valid_out = r_valid;
    assign done_img  = r_done;

    assign w_col_last = (r_col == c_COL_W'(WIDTH - 1));
    assign w_row_last = (r_row == c_ROW_W'(HEIGHT - 1));
    assign w_odd_col  = r_col[0];
    assign w_odd_row  = r_row[0];
    assign w_lb_addr  = c_LB_AW'(r_col >> 1);

    for (genvar i = 0; i < c_NCH; i++) begin : g_ch
        assign w_relu[i] = f_relu(w_in[i]);
        assign w_pair[i] = f_max(r_h[i], w_relu[i]);
        assign w_quad[i] = f_max(r_lb[i][w_lb_addr], w_pair[i]);
    end

    // Position counters, hold registers and pooled outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_col   <= '0;
            r_row   <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            for (int i = 0; i < c_NCH; i++) begin
                r_h[i]    <= '0;
                r_dout[i] <= '0;
            end
        end else begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            if (data_valid_in) begin
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end

                if (!w_odd_col) begin
                    for (int i = 0; i < c_NCH; i++) begin
                        r_h[i] <= w_relu[i];
                    end
                end else if (w_odd_row) begin
                    for (int i = 0; i < c_NCH; i++) begin
                        r_dout[i] <= w_quad[i];
                    end
                    r_valid <= 1'b1;
                    r_done  <= w_row_last && w_col_last;
                end
            end
        end
    end

    // Line buffer: written on even rows, read on odd rows, so no reset needed.
    always_ff @(posedge clk) begin
        if (data_valid_in && w_odd_col && !w_odd_row) begin
            for (int i = 0; i < c_NCH; i++) begin
                r_lb[i][w_lb_addr] <= w_pair[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/relu_maxpool_8chanel.md
# relu_maxpool_8chanel

Downstream stage of the 4-channel/8-filter convolution layer. It consumes the eight 32-bit IEEE-754 single-precision feature-map streams the conv block emits in raster order. It applies ReLU and 2x2 stride-2 max pooling per channel. It emits an (WIDTH/2)x(HEIGHT/2) pooled map per channel with a frame-done pulse, ready for the next conv layer or the flatten/dense stage.

## Interface
Parameters:
- WIDTH, 16, input feature-map width in pixels; must be even, ≥2
- HEIGHT, 16, input feature-map height in pixels; must be even, ≥2
- FILTER, 8, channel count; fixed at 8 by the port list, kept for documentation and consistency checks

Ports:
- clk  input  1  single clock, rising edge
- resetn  input  1  reset, asynchronous, active-low
- data_valid_in  input  1  one pixel (all 8 channels) presented this cycle; driven by conv valid_out
- data_in0..data_in7  input  32 each  channel 0..7 pixel value, IEEE-754 float
- data_out0..data_out7  output  32 each  pooled channel 0..7 value, registered
- valid_out  output  1  data_out* hold one pooled pixel this cycle (single-cycle pulse)
- done_img  output  1  one-cycle pulse coincident with the last pooled pixel of a frame

## Operation
- ReLU per channel: if bit 31 = 1, the value becomes 32'h0000_0000 (also maps -0.0); otherwise unchanged. NaN/Inf inputs are not handled; the producer guarantees finite values.
- After ReLU all values are non-negative. Max is therefore an unsigned compare of bits [30:0]; no FP comparator is used.
- Counters col (0..WIDTH-1) and row (0..HEIGHT-1) advance only on data_valid_in.
  - col wraps to 0 and row increments at col = WIDTH-1.
  - row wraps to 0 at the end of a frame.
- Per channel: hold register h, plus line buffer lb of WIDTH/2 entries × 32 bits. lb is not reset; every entry is written before it is read.
  - Even col: h ← relu(in).
  - Odd col, even row: lb[col>>1] ← max(h, relu(in)).
  - Odd col, odd row: data_out ← max(lb[col>>1], max(h, relu(in))); valid_out ← 1.
  - done_img ← 1 when additionally row = HEIGHT-1 and col = WIDTH-1.
- Outputs per frame: (WIDTH/2)·(HEIGHT/2) valid_out pulses, in raster order of the pooled map.
- Back-to-back frames need no idle cycle; the counters wrap and the next frame starts at (0,0).

## Timing
- Reset values: data_out0..7 = 0, valid_out = 0, done_img = 0, col = 0, row = 0, h = 0.
- Latency: valid_out/data_out appear 1 cycle after the accepting edge of the odd-row, odd-col input.
- data_out* hold their value until the next valid_out. valid_out and done_img are high for exactly one cycle.
- Gaps: data_valid_in may drop for any number of cycles at any pixel. State holds and results are identical to a gap-free stream.
- Throughput: one input pixel per cycle sustained. There is no backpressure; the consumer must accept every valid_out.
- Line-buffer read and write at the same address cannot collide: a row is either write-only (even) or read-only (odd).
- Reset mid-frame: all counters and outputs clear immediately. The next accepted pixel is treated as (0,0) of a new frame. Any partial pool is discarded with no pulse.

## Test plan
(bench uses WIDTH=4, HEIGHT=4)
- Reset with resetn=0 while data_valid_in toggles -> all outputs 0, no valid_out; release, then feed a frame of all 32'h3F800000 (1.0) -> 4 valid_out pulses, each data_out* = 32'h3F800000, done_img only on the 4th.
- ReLU/max: top-left window ch0 = {0xC0400000 (-3.0), 0x3F000000 (0.5); 0x40000000 (2.0), 0x80000000 (-0.0)} -> first data_out0 = 32'h40000000; window of all negatives -> 32'h00000000.
- Per-channel independence: channel k gets value (k+1).0 at the window max position, 0 elsewhere -> data_outk = float(k+1) for all k in the same cycle.
- Gaps: same frame with data_valid_in deasserted for 3 cycles after every 2nd pixel -> identical data_out sequence; each valid_out exactly 1 cycle after the odd/odd input.
- Back-to-back frames: 32 consecutive valid pixels -> 8 valid_out pulses, done_img at pulses 4 and 8, second-frame values not mixed with the first.
- Reset mid-frame: assert resetn=0 after pixel 6, release, send a full frame -> exactly 4 pulses, all from the new frame.
